// File: rtl/note_tone_gen_if.sv
// note_tone_gen_if: control and audio signals of the note tone generator.
//   note_we   - 1-cycle strobe latching note_idx/octave into the pending note
//   note_idx  - semitone 0=C .. 11=B (12..15 invalid)
//   octave    - octave 0..7
//   gate      - 1 = key held, 0 = released
//   tone      - square-wave audio output
//   active    - 1 while the generator is not idle
//   note_err  - 1-cycle pulse after a note_we carrying an invalid note_idx
// The master modport drives the note/gate controls; the slave modport is the generator.
interface note_tone_gen_if;
    logic       note_we;
    logic [3:0] note_idx;
    logic [2:0] octave;
    logic       gate;
    logic       tone;
    logic       active;
    logic       note_err;

    modport master (
        output note_we,
        output note_idx,
        output octave,
        output gate,
        input  tone,
        input  active,
        input  note_err
    );

    modport slave (
        input  note_we,
        input  note_idx,
        input  octave,
        input  gate,
        output tone,
        output active,
        output note_err
    );
endinterface

// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator for 12 semitones in 8 octaves.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, clears all state
//   bus    - note_tone_gen_if slave: note_we/note_idx/octave/gate in,
//            tone/active/note_err out (all outputs registered)
// A half-period counter runs 0..term-1, where term is the octave-shifted half period
// of the active note. Tone toggles at each wrap. Note changes are staged in a
// pending register and only copied into the active note at a wrap, so the output
// never produces runt pulses.
module note_tone_gen #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned CNT_W    = 25,
    parameter int unsigned MIN_HALF = 2
) (
    input  logic             clk,
    input  logic             reset,
    note_tone_gen_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    // Half-period (clocks) of octave-0 note i, rounded down.
    function automatic logic [CNT_W-1:0] half0_of(input int unsigned i);
        logic [63:0] num;
        logic [63:0] f;
        num = 64'(CLK_HZ) * 64'd500;
        case (i)
            0:       f = 64'd16352;
            1:       f = 64'd17324;
            2:       f = 64'd18354;
            3:       f = 64'd19445;
            4:       f = 64'd20602;
            5:       f = 64'd21827;
            6:       f = 64'd23125;
            7:       f = 64'd24500;
            8:       f = 64'd25957;
            9:       f = 64'd27500;
            10:      f = 64'd29135;
            11:      f = 64'd30868;
            default: f = 64'd27500;
        endcase
        return CNT_W'(num / f);
    endfunction

    // Padded to 16 entries so the 4-bit index is always in range; the active note
    // can never hold 12..15, so the padding entries are unreachable.
    localparam logic [CNT_W-1:0] HALF0 [16] = '{
        half0_of(0),  half0_of(1),  half0_of(2),  half0_of(3),
        half0_of(4),  half0_of(5),  half0_of(6),  half0_of(7),
        half0_of(8),  half0_of(9),  half0_of(10), half0_of(11),
        half0_of(9),  half0_of(9),  half0_of(9),  half0_of(9)
    };

    localparam logic [3:0] RST_IDX = 4'd9;
    localparam logic [2:0] RST_OCT = 3'd4;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pend_idx_q, pend_idx_d;
    logic [2:0]       pend_oct_q, pend_oct_d;
    logic [3:0]       act_idx_q, act_idx_d;
    logic [2:0]       act_oct_q, act_oct_d;
    logic             tone_q, tone_d;
    logic             active_q, active_d;
    logic             note_err_q, note_err_d;

    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] term;
    logic             boundary;
    logic             advance;

    always_comb begin
        shifted  = HALF0[act_idx_q] >> act_oct_q;
        term     = (shifted < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : shifted;
        boundary = (cnt_q == term - CNT_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_idx_d = pend_idx_q;
        pend_oct_d = pend_oct_q;
        act_idx_d  = act_idx_q;
        act_oct_d  = act_oct_q;
        tone_d     = tone_q;
        note_err_d = 1'b0;
        // In STOP a re-pressed key resumes normal toggling without a phase reset.
        advance    = (state_q == StRun) || bus.gate;

        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                tone_d = 1'b0;
                if (bus.gate) begin
                    state_d   = StRun;
                    act_idx_d = pend_idx_q;
                    act_oct_d = pend_oct_q;
                end
            end
            StRun, StStop: begin
                state_d = bus.gate ? StRun : StStop;
                if (boundary) begin
                    cnt_d = '0;
                    if (advance) begin
                        tone_d    = ~tone_q;
                        // Old pending value is used even if note_we fires this cycle.
                        act_idx_d = pend_idx_q;
                        act_oct_d = pend_oct_q;
                    end else begin
                        // Released note ends at a half-period edge, never rising.
                        tone_d  = 1'b0;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tone_d  = 1'b0;
            end
        endcase

        if (bus.note_we) begin
            if (bus.note_idx <= 4'd11) begin
                pend_idx_d = bus.note_idx;
                pend_oct_d = bus.octave;
            end else begin
                note_err_d = 1'b1;
            end
        end

        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_idx_q <= RST_IDX;
            pend_oct_q <= RST_OCT;
            act_idx_q  <= RST_IDX;
            act_oct_q  <= RST_OCT;
            tone_q     <= 1'b0;
            active_q   <= 1'b0;
            note_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_idx_q <= pend_idx_d;
            pend_oct_q <= pend_oct_d;
            act_idx_q  <= act_idx_d;
            act_oct_q  <= act_oct_d;
            tone_q     <= tone_d;
            active_q   <= active_d;
            note_err_q <= note_err_d;
        end
    end

    assign bus.tone     = tone_q;
    assign bus.active   = active_q;
    assign bus.note_err = note_err_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen at CLK_HZ = 1 MHz: an event-level model (cycles left until
// the next tone edge) checked every cycle, plus directed timing measurements.
module tb_note_tone_gen;

    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned CNT_W    = 25;
    localparam int unsigned MIN_HALF = 2;

    logic clk;
    logic reset;
    note_tone_gen_if bus ();

    note_tone_gen #(
        .CLK_HZ   (CLK_HZ),
        .CNT_W    (CNT_W),
        .MIN_HALF (MIN_HALF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    int f0_mhz [12] = '{16352, 17324, 18354, 19445, 20602, 21827,
                        23125, 24500, 25957, 27500, 29135, 30868};

    function automatic int term_of(input int idx, input int oct);
        longint h;
        h = (longint'(CLK_HZ) * 500) / longint'(f0_mhz[idx]);
        h = h >>> oct;
        if (h < longint'(MIN_HALF)) h = longint'(MIN_HALF);
        return int'(h);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;   // 0 idle, 1 sounding with key held, 2 sounding after release
    int m_left;   // clocks until the next tone edge
    bit m_tone;
    bit m_err;
    int m_pi, m_po, m_ai, m_ao;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0; m_left = 0; m_tone = 0; m_err = 0;
                m_pi = 9; m_po = 4; m_ai = 9; m_ao = 4;
            end else begin
                bit err_n;
                err_n = bus.note_we && (bus.note_idx > 4'd11);
                if (m_mode == 0) begin
                    m_tone = 0;
                    if (bus.gate) begin
                        m_mode = 1; m_ai = m_pi; m_ao = m_po;
                        m_left = term_of(m_ai, m_ao);
                    end
                end else if (m_left == 1) begin
                    if (m_mode == 1 || bus.gate) begin
                        m_tone = !m_tone; m_ai = m_pi; m_ao = m_po;
                        m_left = term_of(m_ai, m_ao);
                        m_mode = bus.gate ? 1 : 2;
                    end else begin
                        m_tone = 0; m_mode = 0;
                    end
                end else begin
                    m_left--;
                    m_mode = bus.gate ? 1 : 2;
                end
                if (bus.note_we && bus.note_idx <= 4'd11) begin
                    m_pi = int'(bus.note_idx); m_po = int'(bus.octave);
                end
                m_err = err_n;
            end
        end
    end

    // One compare per cycle of {tone, active, note_err}.
    initial begin
        forever begin
            @(negedge clk);
            if (reset)
                check("outputs_in_reset", {bus.tone, bus.active, bus.note_err}, 3'b000);
            else
                check("outputs_vs_model", {bus.tone, bus.active, bus.note_err},
                      {m_tone, (m_mode != 0), m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_note(input int idx, input int oct);
        bus.note_we  = 1'b1;
        bus.note_idx = 4'(idx);
        bus.octave   = 3'(oct);
        tick(1);
        bus.note_we  = 1'b0;
    endtask

    // Clocks until tone rises; -1 if the budget expires.
    task automatic wait_rise(input int budget, output int cycles);
        logic prev;
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            prev = bus.tone;
            tick(1);
            if (!prev && bus.tone) begin cycles = i; break; end
        end
    endtask

    task automatic wait_change(input int budget, output int cycles);
        logic prev;
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            prev = bus.tone;
            tick(1);
            if (prev != bus.tone) begin cycles = i; break; end
        end
    endtask

    // Clocks until active drops; also reports whether tone was ever seen high.
    task automatic wait_idle(input int budget, output int cycles, output bit saw_high);
        cycles = -1;
        saw_high = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (bus.tone) saw_high = 1'b1;
            if (!bus.active) begin cycles = i; break; end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c;
        bit hi;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.note_we = 1'b0; bus.note_idx = 4'd0; bus.octave = 3'd0; bus.gate = 1'b0;

        // Pin the model's term computation with hand-worked values.
        check("term_A4", term_of(9, 4), 1136);
        check("term_C4", term_of(0, 4), 1911);
        check("term_B7", term_of(11, 7), 126);

        tick(3);
        check("reset_tone", bus.tone, 0);
        check("reset_active", bus.active, 0);
        reset = 1'b0;
        tick(2);

        // 1: A4, first rise term clocks after entering RUN, period 2*term.
        write_note(9, 4);
        bus.gate = 1'b1;
        wait_rise(5000, c);
        check("a4_first_rise", c - 1, 1136);
        check("a4_active", bus.active, 1);
        wait_rise(5000, c);
        check("a4_period", c, 2272);

        // 2: note change mid half-period takes effect at the next edge only.
        tick(500);
        write_note(0, 4);
        wait_change(5000, c);
        check("c4_old_half_kept", c, 635);
        wait_change(5000, c);
        check("c4_half_1", c, 1911);
        wait_change(5000, c);
        check("c4_half_2", c, 1911);

        // 4: invalid note index pulses note_err and leaves the timing alone.
        write_note(13, 2);
        check("err_pulse", bus.note_err, 1);
        tick(1);
        check("err_one_cycle", bus.note_err, 0);
        wait_change(5000, c);
        check("err_period_unchanged", c, 1909);

        // 3a: release while tone=1 -> falls at the next edge and goes idle.
        bus.gate = 1'b0;
        wait_change(5000, c);
        check("rel_high_fall", c, 1911);
        check("rel_high_idle", bus.active, 0);
        tick(3);

        // 3b: release while tone=0 -> stays low, idle at the next edge.
        bus.gate = 1'b1;
        wait_change(5000, c);
        wait_change(5000, c);
        bus.gate = 1'b0;
        wait_idle(5000, c, hi);
        check("rel_low_idle_time", c, 1911);
        check("rel_low_no_rise", hi, 0);
        tick(3);

        // 5: sweep of octaves 6 and 7, all 12 semitones.
        for (int o = 6; o <= 7; o++) begin
            for (int i = 0; i < 12; i++) begin
                write_note(i, o);
                bus.gate = 1'b1;
                wait_rise(2000, c);
                check($sformatf("sweep_first_%0d_%0d", i, o), c - 1, term_of(i, o));
                wait_rise(2000, c);
                check($sformatf("sweep_period_%0d_%0d", i, o), c, 2 * term_of(i, o));
                bus.gate = 1'b0;
                wait_idle(2000, c, hi);
                check($sformatf("sweep_idle_%0d_%0d", i, o), (c > 0) ? 1 : 0, 1);
                tick(1);
            end
        end

        // 6: asynchronous reset while tone=1 mid-count, then restart at A4.
        write_note(5, 6);
        bus.gate = 1'b1;
        wait_rise(2000, c);
        tick(10);
        check("pre_reset_tone", bus.tone, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tone", bus.tone, 0);
        check("async_reset_active", bus.active, 0);
        bus.gate = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        bus.gate = 1'b1;
        wait_rise(5000, c);
        check("restart_a4_rise", c - 1, 1136);
        wait_rise(5000, c);
        check("restart_a4_period", c, 2272);
        bus.gate = 1'b0;
        wait_idle(5000, c, hi);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
